// File: rtl/step_pulse_gen.sv
// Step pulse generator: debounced pushbutton with manual single-step or automatic
// free-running step mode, where a key press toggles a pause in automatic mode.
`timescale 1ns/1ps

// state        | meaning
// RELEASED     | key released and stable; key_db=0
// PRESS_WAIT   | key seen pressed; counting stable cycles before accepting
// PRESSED      | key pressed and stable; key_db=1
// RELEASE_WAIT | key seen released; counting stable cycles before accepting
module step_pulse_gen #(
    parameter int DB_CYCLES = 500000,
    parameter int TICK_DIV  = 50000000
) (
    input  logic clk,
    input  logic clear_n,
    input  logic key_0,
    input  logic sw_0,
    output logic step,
    output logic key_db,
    output logic paused
);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } db_state_t;

    localparam logic [23:0] DB_LAST   = 24'(DB_CYCLES - 1);
    localparam logic [25:0] TICK_LAST = 26'(TICK_DIV - 1);

    logic        ks1, ks, ms1, ms;
    logic        ms_prev;
    db_state_t   state;
    logic [23:0] stable_cnt;
    logic [25:0] prescale;
    logic        press_now;

    // ks idles high (key released), ms idles low (manual mode)
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            ks1 <= 1'b1;
            ks  <= 1'b1;
            ms1 <= 1'b0;
            ms  <= 1'b0;
        end else begin
            ks1 <= key_0;
            ks  <= ks1;
            ms1 <= sw_0;
            ms  <= ms1;
        end
    end

    assign press_now = (state == PRESS_WAIT) && !ks && (stable_cnt == DB_LAST);

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state      <= RELEASED;
            stable_cnt <= '0;
            key_db     <= 1'b0;
        end else begin
            case (state)
                RELEASED: begin
                    if (!ks) begin
                        state      <= PRESS_WAIT;
                        stable_cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (ks) begin
                        state <= RELEASED;
                    end else if (stable_cnt == DB_LAST) begin
                        state  <= PRESSED;
                        key_db <= 1'b1;
                    end else begin
                        stable_cnt <= stable_cnt + 24'd1;
                    end
                end
                PRESSED: begin
                    if (ks) begin
                        state      <= RELEASE_WAIT;
                        stable_cnt <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (!ks) begin
                        state <= PRESSED;
                    end else if (stable_cnt == DB_LAST) begin
                        state  <= RELEASED;
                        key_db <= 1'b0;
                    end else begin
                        stable_cnt <= stable_cnt + 24'd1;
                    end
                end
                default: begin
                    state      <= RELEASED;
                    stable_cnt <= '0;
                    key_db     <= 1'b0;
                end
            endcase
        end
    end

    // A mode change wins over everything else in its cycle, including a press.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            ms_prev  <= 1'b0;
            prescale <= '0;
            paused   <= 1'b0;
            step     <= 1'b0;
        end else begin
            ms_prev <= ms;
            step    <= 1'b0;
            if (ms != ms_prev) begin
                prescale <= '0;
                paused   <= 1'b0;
            end else if (!ms) begin
                prescale <= '0;
                paused   <= 1'b0;
                step     <= press_now;
            end else begin
                if (press_now) begin
                    paused <= !paused;
                end
                if (!paused) begin
                    if (prescale == TICK_LAST) begin
                        prescale <= '0;
                        step     <= 1'b1;
                    end else begin
                        prescale <= prescale + 26'd1;
                    end
                end
            end
        end
    end

endmodule
